// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add unsigned multiplier with a fixed latency of WIDTH
// RUN cycles followed by a one-cycle DONE state that presents the product.
module shift_add_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    // state  | meaning
    // S_IDLE | waiting for start
    // S_RUN  | one add/shift step per cycle, WIDTH steps total
    // S_DONE | product just loaded; start here chains the next operation

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   upper;
    logic [WIDTH-1:0]   lower;
    logic [CW-1:0]      step;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   upper_nxt;
    logic [WIDTH-1:0]   lower_nxt;
    logic               last_step;
    logic               accept;

    // {carry, sum, lower} >> 1 lands back in {upper, lower}
    always_comb begin
        sum       = {1'b0, upper} + (lower[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        upper_nxt = sum[WIDTH:1];
        lower_nxt = {sum[0], lower[WIDTH-1:1]};
        last_step = (step == CW'(WIDTH - 1));
        accept    = start && (state != S_RUN);
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_step) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = start ? S_RUN : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            upper   <= '0;
            lower   <= '0;
            step    <= '0;
            product <= '0;
        end else if (accept) begin
            mcand <= a;
            upper <= '0;
            lower <= b;
            step  <= '0;
        end else if (state == S_RUN) begin
            upper <= upper_nxt;
            lower <= lower_nxt;
            step  <= step + CW'(1);
            if (last_step) product <= {upper_nxt, lower_nxt};
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier (WIDTH=32): latency, exactness,
// ignored starts, back-to-back chaining and reset abort.
module tb_shift_add_multiplier;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int checks = 0;
    int errors = 0;

    shift_add_multiplier #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        a = 32'd11;
        b = 32'd13;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b product=%h required busy=0 done=0 product=0",
                     busy, done, product);
        end
        rst = 1'b0;
        start = 1'b0;
    endtask

    // Start is raised one edge before acceptance; done must appear after edge 33.
    task automatic test_single_op(input logic [31:0] ta, input logic [31:0] tbv,
                                  input logic [63:0] exp, input string tag);
        logic [63:0] prev;
        logic [63:0] got;
        int busy_n, done_n, done_at, chg;
        prev = product;
        got = '0;
        busy_n = 0; done_n = 0; done_at = 0; chg = 0;
        a = ta;
        b = tbv;
        start = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            tick();
            if (i == 1) begin
                start = 1'b0;
                a = ~ta;
                b = ~tbv;
            end
            if (busy) begin
                busy_n++;
                if (product !== prev) chg++;
            end
            if (done) begin
                done_n++;
                done_at = i;
                got = product;
            end
        end
        checks++;
        if (busy_n != 32) begin
            errors++;
            $display("FAIL %s busy_cycles got %0d required 32", tag, busy_n);
        end
        checks++;
        if (done_n != 1 || done_at != 33) begin
            errors++;
            $display("FAIL %s done_timing pulses %0d at %0d required 1 at 33", tag, done_n, done_at);
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s product got %h required %h", tag, got, exp);
        end
        checks++;
        if (chg != 0) begin
            errors++;
            $display("FAIL %s product_changed_in_run %0d cycles required 0", tag, chg);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s back_to_idle busy=%b done=%b required 0 0", tag, busy, done);
        end
    endtask

    task automatic test_ignored_start();
        logic [63:0] got;
        int done_n, done_at;
        got = '0;
        done_n = 0; done_at = 0;
        a = 32'd7;
        b = 32'd6;
        start = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            tick();
            if (i == 1) start = 1'b0;
            if (i == 10) begin
                start = 1'b1;
                a = 32'd2;
                b = 32'd2;
            end
            if (i == 11) start = 1'b0;
            if (done) begin
                done_n++;
                done_at = i;
                got = product;
            end
        end
        checks++;
        if (done_n != 1 || done_at != 33) begin
            errors++;
            $display("FAIL ignore done_timing pulses %0d at %0d required 1 at 33", done_n, done_at);
        end
        checks++;
        if (got !== 64'd42) begin
            errors++;
            $display("FAIL ignore product got %h required %h", got, 64'd42);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] p1, p2;
        int d1, d2, n;
        logic busy_at_34;
        p1 = '0; p2 = '0; d1 = 0; d2 = 0; n = 0;
        busy_at_34 = 1'b0;
        a = 32'h0001_0000;
        b = 32'h0001_0000;
        start = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (i == 1) begin
                a = 32'hFFFF_FFFF;
                b = 32'd2;
            end
            if (i == 34) begin
                busy_at_34 = busy;
                start = 1'b0;
            end
            if (done) begin
                n++;
                if (n == 1) begin d1 = i; p1 = product; end
                if (n == 2) begin d2 = i; p2 = product; end
            end
        end
        checks++;
        if (n != 2 || d1 != 33 || d2 != 66) begin
            errors++;
            $display("FAIL b2b done_timing pulses %0d at %0d,%0d required 2 at 33,66", n, d1, d2);
        end
        checks++;
        if (p1 !== 64'h0000_0001_0000_0000) begin
            errors++;
            $display("FAIL b2b product1 got %h required %h", p1, 64'h0000_0001_0000_0000);
        end
        checks++;
        if (p2 !== 64'h0000_0001_FFFF_FFFE) begin
            errors++;
            $display("FAIL b2b product2 got %h required %h", p2, 64'h0000_0001_FFFF_FFFE);
        end
        checks++;
        if (busy_at_34 !== 1'b1) begin
            errors++;
            $display("FAIL b2b no_gap busy=%b required 1", busy_at_34);
        end
    endtask

    task automatic test_reset_mid_run();
        int done_n;
        done_n = 0;
        a = 32'd123;
        b = 32'd123;
        start = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 1) start = 1'b0;
        end
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid_run busy=%b done=%b product=%h required 0 0 0",
                     busy, done, product);
        end
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) done_n++;
        end
        checks++;
        if (done_n != 0) begin
            errors++;
            $display("FAIL reset_no_done pulses %0d required 0", done_n);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single_op(32'd3, 32'd5, 64'd15, "basic_3x5");
        test_single_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max");
        test_single_op(32'h1234_5678, 32'd0, 64'd0, "zero_b");
        test_single_op(32'd0, 32'hDEAD_BEEF, 64'd0, "zero_a");
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_run();
        test_single_op(32'd9, 32'd9, 64'd81, "after_reset_9x9");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
